btb_2bit: RTL and testbench
===========================

# btb_2bit

Parametrised branch target buffer with a 2-bit saturating direction counter per entry, for the five-stage CPU's IF stage. Looks up the fetch PC combinationally and supplies the next-PC prediction in the same cycle. Trains on resolved branches from EX at the clock edge and flags mispredictions to the hazard unit for an IF/ID flush. Replaces the single-bit valid/target BTB with a direct-mapped table of configurable depth, allocate-on-taken policy and hysteresis.

## Interface
- IDX_BITS, 4, log2 of entry count (entries = 2**IDX_BITS); index = PC[IDX_BITS+1:2], tag = PC[31:IDX_BITS+2]
- INIT_CTR, 2, counter value written on allocation (2'b10 = weakly taken)
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- CurrentPC  in  32  IF-stage fetch PC
- PrePC  out  32  predicted next PC: target if predicted taken, else CurrentPC+4
- BTBhit  out  1  valid entry with matching tag at fetch index
- PredTaken  out  1  BTBhit & counter[1]
- PredTarget  out  32  stored target of hit entry (0 on miss); piped down with PredTaken
- bp_clear  in  1  synchronous invalidate of all entries (e.g. context switch)
- ex_br  in  1  EX stage holds a resolved conditional branch this cycle
- ex_taken  in  1  actual direction of the EX branch
- EXpc  in  32  PC of the EX branch
- BrNPC  in  32  actual taken target of the EX branch
- ex_pred_taken  in  1  PredTaken carried to EX with the branch
- ex_pred_target  in  32  PredTarget carried to EX with the branch
- br_mispredict  out  1  combinational: ex_br & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_pred_target != BrNPC))

## Operation
- Storage per entry: valid, tag, 32-bit target, 2-bit counter. Direct-mapped, no replacement choice.
- Lookup (combinational): hit = valid[i] & tag[i]==CurrentPC tag. PredTarget = target[i] on hit, else 0.
- Update at posedge when ex_br=1, index/tag from EXpc:
  - entry hit, taken: counter = min(counter+1, 3); target = BrNPC.
  - entry hit, not taken: counter = max(counter-1, 0); entry stays valid, target unchanged.
  - entry miss, taken: allocate (overwrite any resident entry): valid=1, tag, target=BrNPC, counter=INIT_CTR.
  - entry miss, not taken: no change.
- bp_clear=1: all valid bits cleared at posedge; has priority over a same-cycle update (update dropped).
- br_mispredict is purely combinational from EX inputs; the block does not gate it with internal state.
- Arithmetic: PC+4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000). Counters saturate, never wrap.

## Timing
- Lookup latency 0 cycles: PrePC/BTBhit/PredTaken valid in the same cycle as CurrentPC.
- Update latency 1 cycle: a lookup in the cycle after the update edge sees the new state.
- Same-cycle lookup and update to the same index: lookup returns pre-update (old) contents; no bypass.
- Reset (async assert, any time incl. mid-update): all valid=0, counters=0, targets/tags=0, perf counters=0. With table empty: BTBhit=0, PredTaken=0, PredTarget=0, PrePC=CurrentPC+4. Release synchronised externally; first update accepted at first edge with rst_n=1.

## Configuration
- BTB_PERF_EN defined: adds outputs perf_br_cnt[31:0] (increments on each edge with ex_br=1) and perf_mis_cnt[31:0] (increments on each edge with br_mispredict=1). Both wrap modulo 2^32, reset to 0, unaffected by bp_clear.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset then CurrentPC=0x0000_0040 -> BTBhit=0, PredTaken=0, PrePC=0x0000_0044; CurrentPC=0xFFFF_FFFC -> PrePC=0x0000_0000.
- ex_br=1, ex_taken=1, EXpc=0x100, BrNPC=0x200, ex_pred_taken=0 -> br_mispredict=1; next cycle CurrentPC=0x100 -> BTBhit=1, PredTaken=1, PrePC=0x200.
- Train EXpc=0x100 not-taken twice from INIT_CTR=2 -> counter 0, BTBhit=1, PredTaken=0, PrePC=0x104; two taken -> PredTaken=1 again; five further taken keep counter at 3.
- IDX_BITS=4: allocate 0x100 then taken branch at 0x140 (same index, different tag) -> lookup 0x100 misses, 0x140 hits with new target.
- Same-cycle update of 0x100 and lookup of 0x100 -> old result this cycle, new next; bp_clear with concurrent update -> all lookups miss next cycle.
- BTB_PERF_EN: 10 branches, 3 mispredicts -> perf_br_cnt=10, perf_mis_cnt=3; assert rst_n low mid-sequence -> both 0 immediately.

Source files
------------

// File: rtl/btb_2bit.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
// Defining BTB_PERF_EN adds branch and mispredict event counters (perf_br_cnt, perf_mis_cnt).
module btb_2bit #(
    parameter int         IDX_BITS = 4,
    parameter logic [1:0] INIT_CTR = 2'b10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] CurrentPC,
    output logic [31:0] PrePC,
    output logic        BTBhit,
    output logic        PredTaken,
    output logic [31:0] PredTarget,
    input  logic        bp_clear,
    input  logic        ex_br,
    input  logic        ex_taken,
    input  logic [31:0] EXpc,
    input  logic [31:0] BrNPC,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        br_mispredict
`ifdef BTB_PERF_EN
    ,
    output logic [31:0] perf_br_cnt,
    output logic [31:0] perf_mis_cnt
`endif
);

    localparam int ENTRIES = 2 ** IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [31:0]        targets [ENTRIES];
    logic [1:0]         ctrs    [ENTRIES];

    logic [IDX_BITS-1:0] f_idx;
    logic [IDX_BITS-1:0] e_idx;
    logic [TAG_W-1:0]    f_tag;
    logic [TAG_W-1:0]    e_tag;
    logic                f_hit;
    logic                e_hit;

    assign f_idx = CurrentPC[IDX_BITS+1:2];
    assign f_tag = CurrentPC[31:IDX_BITS+2];
    assign e_idx = EXpc[IDX_BITS+1:2];
    assign e_tag = EXpc[31:IDX_BITS+2];

    assign f_hit = valid[f_idx] && (tags[f_idx] == f_tag);
    assign e_hit = valid[e_idx] && (tags[e_idx] == e_tag);

    // Lookup reads the table as registered, so a same-cycle update is not bypassed.
    assign BTBhit     = f_hit;
    assign PredTaken  = f_hit & ctrs[f_idx][1];
    assign PredTarget = f_hit ? targets[f_idx] : 32'd0;
    assign PrePC      = PredTaken ? PredTarget : CurrentPC + 32'd4;

    assign br_mispredict = ex_br & ((ex_taken != ex_pred_taken) |
                                    (ex_taken & ex_pred_taken & (ex_pred_target != BrNPC)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tags[i]    <= '0;
                targets[i] <= '0;
                ctrs[i]    <= '0;
            end
        end else if (bp_clear) begin
            valid <= '0;
        end else if (ex_br) begin
            if (e_hit) begin
                if (ex_taken) begin
                    if (ctrs[e_idx] != 2'b11) ctrs[e_idx] <= ctrs[e_idx] + 2'd1;
                    targets[e_idx] <= BrNPC;
                end else if (ctrs[e_idx] != 2'b00) begin
                    ctrs[e_idx] <= ctrs[e_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                // Allocate on taken only; any resident entry at this index is evicted.
                valid[e_idx]   <= 1'b1;
                tags[e_idx]    <= e_tag;
                targets[e_idx] <= BrNPC;
                ctrs[e_idx]    <= INIT_CTR;
            end
        end
    end

`ifdef BTB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_cnt  <= '0;
            perf_mis_cnt <= '0;
        end else begin
            if (ex_br)         perf_br_cnt  <= perf_br_cnt + 32'd1;
            if (br_mispredict) perf_mis_cnt <= perf_mis_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_2bit.sv
// Directed bench for btb_2bit: expectations queued as stimulus is driven, popped and checked after settling.
module tb_btb_2bit;

    logic        clk;
    logic        rst_n;
    logic [31:0] CurrentPC;
    logic [31:0] PrePC;
    logic        BTBhit;
    logic        PredTaken;
    logic [31:0] PredTarget;
    logic        bp_clear;
    logic        ex_br;
    logic        ex_taken;
    logic [31:0] EXpc;
    logic [31:0] BrNPC;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        br_mispredict;
`ifdef BTB_PERF_EN
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mis_cnt;
`endif

    btb_2bit #(.IDX_BITS(4), .INIT_CTR(2'b10)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .CurrentPC      (CurrentPC),
        .PrePC          (PrePC),
        .BTBhit         (BTBhit),
        .PredTaken      (PredTaken),
        .PredTarget     (PredTarget),
        .bp_clear       (bp_clear),
        .ex_br          (ex_br),
        .ex_taken       (ex_taken),
        .EXpc           (EXpc),
        .BrNPC          (BrNPC),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .br_mispredict  (br_mispredict)
`ifdef BTB_PERF_EN
        ,
        .perf_br_cnt    (perf_br_cnt),
        .perf_mis_cnt   (perf_mis_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(input string name);
        if (name == "BTBhit")        return {31'd0, BTBhit};
        if (name == "PredTaken")     return {31'd0, PredTaken};
        if (name == "PredTarget")    return PredTarget;
        if (name == "PrePC")         return PrePC;
        if (name == "br_mispredict") return {31'd0, br_mispredict};
`ifdef BTB_PERF_EN
        if (name == "perf_br_cnt")   return perf_br_cnt;
        if (name == "perf_mis_cnt")  return perf_mis_cnt;
`endif
        return 32'hxxxx_xxxx;
    endfunction

    task automatic push(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        #1;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observe(e.name);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic hit, input logic tk,
                        input logic [31:0] tgt, input logic [31:0] prepc);
        CurrentPC = pc;
        push("BTBhit", {31'd0, hit});
        push("PredTaken", {31'd0, tk});
        push("PredTarget", tgt);
        push("PrePC", prepc);
        drain();
    endtask

    task automatic br(input logic tk, input logic [31:0] pc, input logic [31:0] npc,
                      input logic ptk, input logic [31:0] ptgt, input logic mis);
        ex_br          = 1'b1;
        ex_taken       = tk;
        EXpc           = pc;
        BrNPC          = npc;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
        push("br_mispredict", {31'd0, mis});
        drain();
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        ex_br    = 1'b0;
        bp_clear = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        CurrentPC      = 32'h0;
        bp_clear       = 1'b0;
        ex_br          = 1'b0;
        ex_taken       = 1'b0;
        EXpc           = 32'h0;
        BrNPC          = 32'h0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 32'h0;

        // Reset state and PC+4 wrap
        look(32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0000_0044);
        @(negedge clk);
        rst_n = 1'b1;
        look(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0000_0000);
        push("br_mispredict", 32'd0);
        drain();

        // Allocate on taken miss
        br(1'b1, 32'h100, 32'h200, 1'b0, 32'h0, 1'b1);
        look(32'h100, 1'b0, 1'b0, 32'h0, 32'h104);
        step();
        look(32'h100, 1'b1, 1'b1, 32'h200, 32'h200);

        // Counter training with saturation at both ends
        br(1'b0, 32'h100, 32'h200, 1'b1, 32'h200, 1'b1); step();
        look(32'h100, 1'b1, 1'b0, 32'h200, 32'h104);
        br(1'b0, 32'h100, 32'h200, 1'b1, 32'h200, 1'b1); step();
        look(32'h100, 1'b1, 1'b0, 32'h200, 32'h104);
        br(1'b0, 32'h100, 32'h200, 1'b0, 32'h200, 1'b0); step();
        look(32'h100, 1'b1, 1'b0, 32'h200, 32'h104);
        br(1'b1, 32'h100, 32'h200, 1'b0, 32'h200, 1'b1); step();
        look(32'h100, 1'b1, 1'b0, 32'h200, 32'h104);
        br(1'b1, 32'h100, 32'h300, 1'b0, 32'h200, 1'b1); step();
        look(32'h100, 1'b1, 1'b1, 32'h300, 32'h300);
        for (int i = 0; i < 6; i++) begin
            br(1'b1, 32'h100, 32'h300, 1'b1, 32'h300, 1'b0);
            step();
        end
        look(32'h100, 1'b1, 1'b1, 32'h300, 32'h300);
        br(1'b1, 32'h100, 32'h340, 1'b1, 32'h300, 1'b1); step();
        look(32'h100, 1'b1, 1'b1, 32'h340, 32'h340);
        br(1'b0, 32'h100, 32'h340, 1'b1, 32'h340, 1'b1); step();
        look(32'h100, 1'b1, 1'b1, 32'h340, 32'h340);
        br(1'b0, 32'h100, 32'h340, 1'b1, 32'h340, 1'b1); step();
        look(32'h100, 1'b1, 1'b0, 32'h340, 32'h104);

        // Aliasing: same index, different tag evicts
        br(1'b1, 32'h140, 32'h500, 1'b0, 32'h0, 1'b1); step();
        look(32'h100, 1'b0, 1'b0, 32'h0, 32'h104);
        look(32'h140, 1'b1, 1'b1, 32'h500, 32'h500);

        // Same-cycle lookup sees old contents
        br(1'b1, 32'h100, 32'h600, 1'b0, 32'h0, 1'b1);
        look(32'h100, 1'b0, 1'b0, 32'h0, 32'h104);
        step();
        look(32'h100, 1'b1, 1'b1, 32'h600, 32'h600);
        look(32'h140, 1'b0, 1'b0, 32'h0, 32'h144);

        // Not-taken miss does not allocate
        br(1'b0, 32'h200, 32'h900, 1'b0, 32'h0, 1'b0); step();
        look(32'h200, 1'b0, 1'b0, 32'h0, 32'h204);
        look(32'h100, 1'b1, 1'b1, 32'h600, 32'h600);

        // bp_clear beats a concurrent update
        bp_clear = 1'b1;
        br(1'b1, 32'h184, 32'h700, 1'b0, 32'h0, 1'b1);
        look(32'h100, 1'b1, 1'b1, 32'h600, 32'h600);
        step();
        look(32'h100, 1'b0, 1'b0, 32'h0, 32'h104);
        look(32'h184, 1'b0, 1'b0, 32'h0, 32'h188);

        // Asynchronous reset during a pending update
        br(1'b1, 32'h100, 32'h600, 1'b0, 32'h0, 1'b1); step();
        look(32'h100, 1'b1, 1'b1, 32'h600, 32'h600);
        br(1'b1, 32'h100, 32'h800, 1'b1, 32'h600, 1'b1);
        #1 rst_n = 1'b0;
        look(32'h100, 1'b0, 1'b0, 32'h0, 32'h104);
        @(negedge clk);
        ex_br = 1'b0;
        rst_n = 1'b1;
        look(32'h100, 1'b0, 1'b0, 32'h0, 32'h104);

`ifdef BTB_PERF_EN
        for (int i = 0; i < 10; i++) begin
            br(1'b1, 32'h1000 + 32'(4 * i), 32'h2000, (i >= 3), 32'h2000, (i < 3));
            step();
        end
        push("perf_br_cnt", 32'd10);
        push("perf_mis_cnt", 32'd3);
        drain();
        bp_clear = 1'b1;
        step();
        push("perf_br_cnt", 32'd10);
        push("perf_mis_cnt", 32'd3);
        drain();
        #1 rst_n = 1'b0;
        push("perf_br_cnt", 32'd0);
        push("perf_mis_cnt", 32'd0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
